// File: rtl/class_argmax.sv
// Streaming argmax over ten signed class scores; publishes a registered one-hot winner code.
// Optional runner-up margin check enabled by defining ARGMAX_MARGIN_EN.
module class_argmax #(
  parameter int DATA_W = 16,
  parameter int MARGIN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              score_valid,
  input  logic [DATA_W-1:0] score_data,
  input  logic              score_last,
  output logic              score_ready,
  output logic [9:0]        code,
  output logic              code_valid,
  output logic              frame_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [3:0]        max_idx_q, max_idx_d;
  logic [9:0]        code_q, code_d;
  logic              code_valid_q, code_valid_d;
  logic              frame_err_q, frame_err_d;

  logic accept;
  logic last_slot;
  logic low_margin;

  assign score_ready = (state_q != StDone);
  assign accept      = score_valid & score_ready;
  assign last_slot   = (idx_q == 4'd9);

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [DATA_W:0] MarginV = (DATA_W+1)'(MARGIN);

  logic [DATA_W-1:0]   sec_val_q, sec_val_d;
  logic                sec_valid_q, sec_valid_d;
  logic signed [DATA_W:0] margin_diff;

  // Sign-extend by one bit so the difference of two extreme scores cannot wrap.
  assign margin_diff = $signed({max_val_q[DATA_W-1], max_val_q})
                     - $signed({sec_val_q[DATA_W-1], sec_val_q});
  assign low_margin  = sec_valid_q && (margin_diff < MarginV);
`else
  logic unused_margin;
  assign unused_margin = ^MARGIN;
  assign low_margin    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    max_val_d    = max_val_q;
    max_idx_d    = max_idx_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
`ifdef ARGMAX_MARGIN_EN
    sec_val_d    = sec_val_q;
    sec_valid_d  = sec_valid_q;
`endif
    case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          if (state_q == StIdle) begin
            max_val_d = score_data;
            max_idx_d = 4'd0;
`ifdef ARGMAX_MARGIN_EN
            sec_valid_d = 1'b0;
`endif
          end else if ($signed(score_data) > $signed(max_val_q)) begin
            max_val_d = score_data;
            max_idx_d = idx_q;
`ifdef ARGMAX_MARGIN_EN
            sec_val_d   = max_val_q;
            sec_valid_d = 1'b1;
`endif
          end
`ifdef ARGMAX_MARGIN_EN
          else if (!sec_valid_q || ($signed(score_data) > $signed(sec_val_q))) begin
            sec_val_d   = score_data;
            sec_valid_d = 1'b1;
          end
`endif
          idx_d   = idx_q + 4'd1;
          state_d = StAccum;
          if (score_last != last_slot) frame_err_d = 1'b1;
          if (score_last || last_slot) state_d = StDone;
        end
      end
      StDone: begin
        state_d      = StIdle;
        idx_d        = 4'd0;
        code_valid_d = 1'b1;
        code_d       = low_margin ? 10'd0 : (10'd1 << max_idx_q);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= 4'd0;
      max_val_q    <= '0;
      max_idx_q    <= 4'd0;
      code_q       <= 10'd0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      sec_val_q    <= '0;
      sec_valid_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef ARGMAX_MARGIN_EN
      sec_val_q    <= sec_val_d;
      sec_valid_q  <= sec_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_class_argmax.sv
// Randomised self-checking bench for class_argmax; frames are scored by a queue-based model.
// Define ARGMAX_MARGIN_EN to also exercise the runner-up margin (MARGIN = 4).
module tb_class_argmax;

`ifdef ARGMAX_MARGIN_EN
  localparam int Margin = 4;
`else
  localparam int Margin = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        score_valid;
  logic [15:0] score_data;
  logic        score_last;
  logic        score_ready;
  logic [9:0]  code;
  logic        code_valid;
  logic        frame_err;

  int tests = 0;
  int fails = 0;

  int         fr[$];
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [9:0] last_exp;
  bit         err_exp;
  int         ready_low = 0;

  class_argmax #(.DATA_W(16), .MARGIN(Margin)) dut (
    .clk(clk), .rst(rst), .score_valid(score_valid), .score_data(score_data),
    .score_last(score_last), .score_ready(score_ready), .code(code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Expected winner of the frame held in fr: first strict maximum, optional margin blanking.
  function automatic logic [9:0] ref_code();
    int bi;
    int sec;
    bit have;
    bi = 0;
    sec = 0;
    have = 0;
    for (int i = 1; i < fr.size(); i++) if (fr[i] > fr[bi]) bi = i;
`ifdef ARGMAX_MARGIN_EN
    for (int i = 0; i < fr.size(); i++) begin
      if (i != bi && (!have || fr[i] > sec)) begin
        sec = fr[i];
        have = 1;
      end
    end
    if (have && (fr[bi] - sec) < Margin) return 10'd0;
`endif
    return 10'd1 << bi;
  endfunction

  task automatic model_beat(input int d, input bit last);
    fr.push_back(d);
    if (last != (fr.size() == 10)) err_exp = 1;
    if (last || fr.size() == 10) begin
      last_exp = ref_code();
      exp_q.push_back(last_exp);
      fr.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !score_ready) ready_low++;
    if (code_valid) begin
      got_q.push_back(code);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: code=%b, no result was due", code);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (code !== e) begin
          fails++;
          $display("FAIL result_code: got %b, expected %b", code, e);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input int d, input bit last);
    int waitc;
    waitc = 0;
    score_valid = 1'b1;
    score_data  = 16'(d);
    score_last  = last;
    while (!score_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!score_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: score_ready=%b after %0d cycles, expected 1", score_ready,
               waitc);
    end else begin
      @(posedge clk);
      model_beat(d, last);
      @(negedge clk);
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic send_frame(input int s[10], input int n, input bit last_end, input int maxgap);
    for (int i = 0; i < n; i++) begin
      send_beat(s[i], last_end && (i == n - 1));
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  task automatic drain();
    repeat (5) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL results_missing: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (code !== 10'd0 || code_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: code=%b cv=%b err=%b, expected 0 0 0", code, code_valid,
               frame_err);
    end
    rst = 1'b0;
    fr.delete();
    err_exp = 0;
    @(negedge clk);
    tests++;
    if (score_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, expected 1", score_ready);
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 10; i++) send_beat(i, i == 9);
    tests++;
    if (score_ready !== 1'b0 || code_valid !== 1'b0) begin
      fails++;
      $display("FAIL ramp_done_cycle: ready=%b cv=%b, expected 0 0", score_ready, code_valid);
    end
    @(negedge clk);
    tests++;
    if (code_valid !== 1'b1 || code !== last_exp || score_ready !== 1'b1) begin
      fails++;
      $display("FAIL ramp_commit: cv=%b code=%b ready=%b, expected 1 %b 1", code_valid, code,
               score_ready, last_exp);
    end
    @(negedge clk);
    tests++;
    if (code_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL ramp_after: cv=%b err=%b, expected 0 0", code_valid, frame_err);
    end
    drain();
  endtask

  task automatic test_ties();
    int a[10] = '{5, -3, 7, 7, 2, 0, 0, 0, 0, -32768};
    int b[10] = '{-5, -9, -100, -2, -30000, -7, -1, -3, -1, -20};
    send_frame(a, 10, 1, 0);
    drain();
    send_frame(b, 10, 1, 0);
    drain();
    tests++;
    if (code !== last_exp) begin
      fails++;
      $display("FAIL negative_frame: got %b, expected %b", code, last_exp);
    end
  endtask

  task automatic test_framing();
    int a[10] = '{3, 900, 1, 2, 0, 0, 0, 0, 0, 0};
    int b[10] = '{4, 8, 1, 30, 2, 6, 9, 0, 5, 7};
    send_frame(a, 4, 1, 0);
    tests++;
    if (frame_err !== 1'b1) begin
      fails++;
      $display("FAIL early_last_err: got %b, expected 1", frame_err);
    end
    drain();
    tests++;
    if (code !== last_exp) begin
      fails++;
      $display("FAIL early_last_code: got %b, expected %b", code, last_exp);
    end
    send_frame(b, 10, 0, 0);
    send_beat(11, 0);
    send_beat(-4, 1);
    drain();
    tests++;
    if (frame_err !== err_exp) begin
      fails++;
      $display("FAIL missing_last_err: got %b, expected %b", frame_err, err_exp);
    end
  endtask

  task automatic test_reset_midframe();
    int a[10] = '{1, 2, 3, 4, 50, 5, 6, 7, 8, 9};
    int p[10] = '{9, 9, 99, 9, 9, 0, 0, 0, 0, 0};
    send_frame(p, 5, 0, 0);
    rst = 1'b1;
    fr.delete();
    err_exp = 0;
    @(negedge clk);
    tests++;
    if (code !== 10'd0 || code_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL midframe_reset: code=%b cv=%b err=%b, expected 0 0 0", code, code_valid,
               frame_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(a, 10, 1, 0);
    drain();
    tests++;
    if (code !== last_exp) begin
      fails++;
      $display("FAIL post_reset_frame: got %b, expected %b", code, last_exp);
    end
  endtask

  task automatic test_gapped_b2b();
    int f[3][10];
    logic [9:0] gapped[$];
    int rl0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 10; i++) f[k][i] = int'($urandom_range(0, 2000)) - 1000;
    got_q.delete();
    for (int k = 0; k < 3; k++) send_frame(f[k], 10, 1, 3);
    drain();
    gapped = got_q;
    got_q.delete();
    rl0 = ready_low;
    for (int k = 0; k < 3; k++) send_frame(f[k], 10, 1, 0);
    drain();
    tests++;
    if (ready_low - rl0 != 3) begin
      fails++;
      $display("FAIL ready_low_cycles: got %0d, expected 3", ready_low - rl0);
    end
    tests++;
    if (got_q.size() != 3 || gapped.size() != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d/%0d, expected 3/3", got_q.size(), gapped.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (got_q[k] !== gapped[k]) begin
          fails++;
          $display("FAIL b2b_vs_gapped[%0d]: got %b, expected %b", k, got_q[k], gapped[k]);
        end
      end
    end
  endtask

`ifdef ARGMAX_MARGIN_EN
  task automatic test_margin();
    int a[10] = '{1, 0, 10, -2, 3, 7, 5, -9, 2, 0};
    int b[10] = '{1, 0, 12, -2, 3, 7, 5, -9, 2, 0};
    int c[10] = '{-32768, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(a, 10, 1, 0);
    drain();
    tests++;
    if (code !== 10'd0) begin
      fails++;
      $display("FAIL margin_blank: got %b, expected 0", code);
    end
    send_frame(b, 10, 1, 0);
    drain();
    tests++;
    if (code !== 10'b0000000100) begin
      fails++;
      $display("FAIL margin_pass: got %b, expected 0000000100", code);
    end
    send_frame(c, 1, 1, 0);
    drain();
    tests++;
    if (code !== 10'b0000000001) begin
      fails++;
      $display("FAIL margin_single: got %b, expected 0000000001", code);
    end
  endtask
`endif

  task automatic test_random();
    int s[10];
    int kind;
    test_reset();
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 25; k++) begin
        for (int i = 0; i < 10; i++) begin
          if ($urandom_range(0, 1) == 1) s[i] = int'($urandom_range(0, 6)) - 3;
          else s[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        kind = (ph == 0) ? 0 : int'($urandom_range(0, 3));
        if (kind <= 1) send_frame(s, 10, 1, 2);
        else if (kind == 2) send_frame(s, 10, 0, 2);
        else send_frame(s, int'($urandom_range(1, 9)), 1, 2);
      end
      drain();
      tests++;
      if (frame_err !== err_exp) begin
        fails++;
        $display("FAIL random_err_phase%0d: got %b, expected %b", ph, frame_err, err_exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    score_valid = 1'b0;
    score_data = '0;
    score_last = 1'b0;
    err_exp = 0;
    last_exp = '0;
    @(negedge clk);
    test_reset();
    test_ramp();
    test_ties();
    test_framing();
    test_reset_midframe();
    test_gapped_b2b();
`ifdef ARGMAX_MARGIN_EN
    test_margin();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
